soc_test_monitor: RTL and testbench

SOC_TEST_MONITOR -- requirements
Module: soc_test_monitor

---
 rtl/soc_test_monitor.sv | 117 +++++++++++
 tb/tb_soc_test_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/soc_test_monitor.sv
// soc_test_monitor: run-state tracker with data-window violation capture and optional watchdog.
// Define MON_READ_CHECK_EN to police reads as well as writes.
module soc_test_monitor #(
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int MAX_CYCLES  = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_base_i,
    input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_limit_i,
    input  logic                              data_req_i,
    input  logic                              data_gnt_i,
    input  logic                              data_we_i,
    input  logic [ADDR_WIDTH-1:0]             data_addr_i,
    input  logic                              tests_passed_i,
    input  logic                              tests_failed_i,
    input  logic                              exit_valid_i,
    input  logic [31:0]                       exit_value_i,
    output logic [2:0]                        state_o,
    output logic                              done_o,
    output logic [CNT_WIDTH-1:0]              cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]              viol_cnt_o,
    output logic                              viol_valid_o,
    output logic [ADDR_WIDTH-1:0]             viol_addr_o,
    output logic [31:0]                       exit_code_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;
    state_t                r_state, w_next;
    logic [CNT_WIDTH-1:0]  r_cycle_cnt, r_viol_cnt;
    logic                  r_viol_valid;
    logic [ADDR_WIDTH-1:0] r_viol_addr;
    logic [31:0]           r_exit_code;
    logic                  w_access, w_legal, w_viol, w_wdog, w_exit_cap;
`ifdef MON_READ_CHECK_EN
    logic w_unused_we;
    assign w_unused_we = data_we_i;
    assign w_access    = data_req_i & data_gnt_i;
`else
    assign w_access    = data_req_i & data_gnt_i & data_we_i;
`endif
    // An inverted window (base > limit) can never satisfy both bounds, so it matches nothing.
    always_comb begin
        w_legal = 1'b0;
        for (int k = 0; k < NUM_REGIONS; k++)
            if (data_addr_i >= region_base_i[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                data_addr_i <= region_limit_i[k*ADDR_WIDTH +: ADDR_WIDTH])
                w_legal = 1'b1;
    end
    assign w_viol = (r_state == S_RUN) & w_access & ~w_legal & ~start_i;
    assign w_wdog = (MAX_CYCLES != 0) && (r_cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1));
    always_comb begin
        w_next     = r_state;
        w_exit_cap = 1'b0;
        if (start_i)
            w_next = S_RUN;
        else if (r_state == S_RUN) begin
            if (tests_failed_i)
                w_next = S_FAIL;
            else if (exit_valid_i && exit_value_i != 32'd0) begin
                w_next     = S_FAIL;
                w_exit_cap = 1'b1;
            end else if (tests_passed_i)
                w_next = S_PASS;
            else if (exit_valid_i) begin
                w_next     = S_PASS;
                w_exit_cap = 1'b1;
            end else if (w_wdog)
                w_next = S_TIMEOUT;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cycle_cnt  <= '0;
            r_viol_cnt   <= '0;
            r_viol_valid <= 1'b0;
            r_viol_addr  <= '0;
            r_exit_code  <= '0;
        end else begin
            r_state <= w_next;
            if (start_i) begin
                r_cycle_cnt  <= '0;
                r_viol_cnt   <= '0;
                r_viol_valid <= 1'b0;
                r_viol_addr  <= '0;
                r_exit_code  <= '0;
            end else begin
                if (r_state == S_RUN && ~&r_cycle_cnt)
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                if (w_viol && ~&r_viol_cnt)
                    r_viol_cnt <= r_viol_cnt + 1'b1;
                if (w_viol && !r_viol_valid) begin
                    r_viol_valid <= 1'b1;
                    r_viol_addr  <= data_addr_i;
                end
                if (w_exit_cap)
                    r_exit_code <= exit_value_i;
            end
        end
    end
    assign state_o      = r_state;
    assign done_o       = (r_state == S_PASS) | (r_state == S_FAIL) | (r_state == S_TIMEOUT);
    assign cycle_cnt_o  = r_cycle_cnt;
    assign viol_cnt_o   = r_viol_cnt;
    assign viol_valid_o = r_viol_valid;
    assign viol_addr_o  = r_viol_addr;
    assign exit_code_o  = r_exit_code;
endmodule

// File: tb/tb_soc_test_monitor.sv
// tb_soc_test_monitor: directed and randomized checks of soc_test_monitor against a rule-level model.
module tb_soc_test_monitor;
    localparam int MAXC = 10;
`ifdef MON_READ_CHECK_EN
    localparam bit RD = 1'b1;
`else
    localparam bit RD = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_i = 0, data_req_i = 0, data_gnt_i = 0, data_we_i = 0;
    logic [31:0] data_addr_i = 0, exit_value_i = 0;
    logic        tests_passed_i = 0, tests_failed_i = 0, exit_valid_i = 0;
    logic [63:0] region_base_i  = {32'h1A000000, 32'h00200000};
    logic [63:0] region_limit_i = {32'h1A0000FF, 32'h00240000};
    logic [2:0]  state_o;
    logic        done_o, viol_valid_o;
    logic [31:0] cycle_cnt_o, viol_cnt_o, viol_addr_o, exit_code_o;
    int checks = 0, errors = 0;

    soc_test_monitor #(.NUM_REGIONS(2), .ADDR_WIDTH(32), .CNT_WIDTH(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .region_base_i(region_base_i), .region_limit_i(region_limit_i),
        .data_req_i(data_req_i), .data_gnt_i(data_gnt_i), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .tests_passed_i(tests_passed_i),
        .tests_failed_i(tests_failed_i), .exit_valid_i(exit_valid_i),
        .exit_value_i(exit_value_i), .state_o(state_o), .done_o(done_o),
        .cycle_cnt_o(cycle_cnt_o), .viol_cnt_o(viol_cnt_o), .viol_valid_o(viol_valid_o),
        .viol_addr_o(viol_addr_o), .exit_code_o(exit_code_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] cyc;
        logic [31:0] viol;
        logic        vv;
        logic [31:0] va;
        logic [31:0] ex;
    } model_t;
    model_t m;

    function automatic bit legal(input logic [31:0] a);
        for (int k = 0; k < 2; k++)
            if (a >= region_base_i[k*32 +: 32] && a <= region_limit_i[k*32 +: 32]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of the run rules: what the outputs become after this cycle's inputs.
    function automatic model_t step(input model_t c);
        model_t n = c;
        bit acc = data_req_i && data_gnt_i && (data_we_i || RD);
        if (start_i) return '{st: 3'd1, default: '0};
        if (c.st != 3'd1) return n;
        if (c.cyc != 32'hFFFFFFFF) n.cyc = c.cyc + 1;
        if (acc && !legal(data_addr_i)) begin
            if (c.viol != 32'hFFFFFFFF) n.viol = c.viol + 1;
            if (!c.vv) begin n.vv = 1'b1; n.va = data_addr_i; end
        end
        if (tests_failed_i) n.st = 3'd3;
        else if (exit_valid_i && exit_value_i != 0) begin n.st = 3'd3; n.ex = exit_value_i; end
        else if (tests_passed_i) n.st = 3'd2;
        else if (exit_valid_i) begin n.st = 3'd2; n.ex = exit_value_i; end
        else if (MAXC != 0 && c.cyc == MAXC - 1) n.st = 3'd4;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '0;
        else m <= step(m);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("m_state", 32'(state_o), 32'(m.st));
        chk("m_done", 32'(done_o), 32'(m.st >= 3'd2));
        chk("m_cycle", cycle_cnt_o, m.cyc);
        chk("m_viol", viol_cnt_o, m.viol);
        chk("m_vvalid", 32'(viol_valid_o), 32'(m.vv));
        chk("m_vaddr", viol_addr_o, m.va);
        chk("m_exit", exit_code_o, m.ex);
    end

    task automatic go(input bit st, input bit req, input bit we, input logic [31:0] a,
                      input bit tp, input bit tf, input bit ev, input logic [31:0] val);
        start_i = st; data_req_i = req; data_gnt_i = req; data_we_i = we; data_addr_i = a;
        tests_passed_i = tp; tests_failed_i = tf; exit_valid_i = ev; exit_value_i = val;
        @(negedge clk);
    endtask

    task automatic idle();
        go(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] al[8] = '{32'h00200000, 32'h00240000, 32'h1A0000FF, 32'h001FFFFC,
                           32'h00240004, 32'h1A000100, 32'h0, 32'h1A000000};

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_done", 32'(done_o), 0);
        rst_n = 1'b1;
        go(1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 1, 1, 32'h00200000, 0, 0, 0, 0);
        go(0, 1, 1, 32'h00240000, 0, 0, 0, 0);
        go(0, 1, 1, 32'h1A0000FF, 0, 0, 0, 0);
        idle();
        chk("legal_state", 32'(state_o), 1);
        chk("legal_cycle", cycle_cnt_o, 4);
        chk("legal_viol", viol_cnt_o, 0);
        chk("legal_vvalid", 32'(viol_valid_o), 0);
        go(0, 1, 1, 32'h001FFFFC, 0, 0, 0, 0);
        go(0, 1, 1, 32'h00240004, 0, 0, 0, 0);
        go(0, 1, 0, 32'h0, 0, 0, 0, 0);
        idle();
        chk("viol_cnt", viol_cnt_o, RD ? 3 : 2);
        chk("viol_addr", viol_addr_o, 32'h001FFFFC);
        chk("viol_valid", 32'(viol_valid_o), 1);
        go(0, 0, 0, 0, 1, 1, 0, 0);
        chk("tf_tp_state", 32'(state_o), 3);
        chk("tf_tp_done", 32'(done_o), 1);
        chk("tf_tp_cycle", cycle_cnt_o, 9);
        idle();
        chk("fail_hold", 32'(state_o), 3);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 5);
        chk("exit5_state", 32'(state_o), 3);
        chk("exit5_code", exit_code_o, 5);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        chk("restart_exit", exit_code_o, 0);
        chk("restart_cycle", cycle_cnt_o, 0);
        go(0, 1, 1, 32'h0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0);
        chk("pass_state", 32'(state_o), 2);
        chk("pass_viol", viol_cnt_o, 1);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        chk("pass_restart_state", 32'(state_o), 1);
        chk("pass_restart_viol", viol_cnt_o, 0);
        chk("pass_restart_vvalid", 32'(viol_valid_o), 0);
        go(0, 0, 0, 0, 1, 0, 1, 7);
        chk("exit7_prio_state", 32'(state_o), 3);
        chk("exit7_code", exit_code_o, 7);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) idle();
        chk("wd_pre_state", 32'(state_o), 1);
        chk("wd_pre_cycle", cycle_cnt_o, 9);
        idle();
        chk("wd_state", 32'(state_o), 4);
        chk("wd_cycle", cycle_cnt_o, 10);
        chk("wd_done", 32'(done_o), 1);
        idle();
        chk("wd_hold_cycle", cycle_cnt_o, 10);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        go(0, 1, 1, 32'h10, 0, 0, 0, 0);
        go(0, 1, 1, 32'h00300000, 0, 0, 0, 0);
        go(0, 1, 1, 32'h1A000100, 0, 0, 0, 0);
        chk("pre_rst_viol", viol_cnt_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 0);
        chk("arst_done", 32'(done_o), 0);
        chk("arst_viol", viol_cnt_o, 0);
        chk("arst_cycle", cycle_cnt_o, 0);
        chk("arst_vvalid", 32'(viol_valid_o), 0);
        chk("arst_vaddr", viol_addr_o, 0);
        chk("arst_exit", exit_code_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_rst_state", 32'(state_o), 0);
        for (int i = 0; i < 800; i++) begin
            bit st = ($urandom % 12) == 0;
            rst_n = ($urandom % 150) != 0;
            go(st, !st && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               ($urandom % 4 == 0) ? $urandom : al[$urandom % 8],
               ($urandom % 24) == 0, ($urandom % 30) == 0, ($urandom % 20) == 0,
               ($urandom % 2 == 0) ? 32'd0 : 32'($urandom % 4));
        end
        rst_n = 1'b1;
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
